// File: rtl/ddr3_cmd_arbiter.sv
// N-port round-robin front-end for the DDR3 controller: tags accepted commands
// with the winning port ID and streams BLW write bursts from a locked port.
module ddr3_cmd_arbiter #(
    parameter int NPORTS = 2,
    parameter int PIDW   = 1,
    parameter int DW     = 16,
    parameter int AW     = 26
) (
    input  logic                         clk,
    input  logic                         resetbar,
    input  logic                         ready,
    input  logic [3*NPORTS-1:0]          port_cmd,
    input  logic [AW*NPORTS-1:0]         port_addr,
    input  logic [2*NPORTS-1:0]          port_sz,
    input  logic [3*NPORTS-1:0]          port_op,
    input  logic [DW*NPORTS-1:0]         port_din,
    input  logic [NPORTS-1:0]            port_wvalid,
    output logic [NPORTS-1:0]            port_ack,
    output logic [NPORTS-1:0]            port_dack,
    input  logic                         cmd_full,
    output logic                         cmd_put,
    output logic [3+AW+2+3+PIDW-1:0]     cmd_data,
    input  logic                         data_full,
    output logic                         data_put,
    output logic [DW-1:0]                data_out,
    output logic                         busy
);

    localparam logic [2:0] CMD_SCR = 3'd1;
    localparam logic [2:0] CMD_SCW = 3'd2;
    localparam logic [2:0] CMD_BLR = 3'd3;
    localparam logic [2:0] CMD_BLW = 3'd4;
    localparam logic [2:0] CMD_ATR = 3'd5;
    localparam logic [2:0] CMD_ATW = 3'd6;

    typedef enum logic {IDLE, BURST} state_t;

    state_t            state, state_nxt;
    logic [PIDW-1:0]   rr_ptr, rr_nxt;
    logic [PIDW-1:0]   lock, lock_nxt;
    logic [4:0]        bcnt, bcnt_nxt;

    logic [NPORTS-1:0] is_rd, is_wr, elig;
    logic              found;
    logic [PIDW-1:0]   win;
    logic [2:0]        win_cmd;
    logic [1:0]        win_sz;

    always_comb begin
        is_rd = '0;
        is_wr = '0;
        elig  = '0;
        for (int p = 0; p < NPORTS; p++) begin
            is_rd[p] = (port_cmd[p*3 +: 3] == CMD_SCR) || (port_cmd[p*3 +: 3] == CMD_BLR);
            is_wr[p] = (port_cmd[p*3 +: 3] == CMD_SCW) || (port_cmd[p*3 +: 3] == CMD_BLW) ||
                       (port_cmd[p*3 +: 3] == CMD_ATR) || (port_cmd[p*3 +: 3] == CMD_ATW);
            elig[p]  = ready & ~cmd_full & (is_rd[p] | (is_wr[p] & ~data_full));
        end
    end

    // Blocked writes are simply not eligible, so the scan skips past them.
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int k = 0; k < NPORTS; k++) begin
            if (!found && elig[(int'(rr_ptr) + k) % NPORTS]) begin
                found = 1'b1;
                win   = PIDW'((int'(rr_ptr) + k) % NPORTS);
            end
        end
    end

    assign win_cmd = port_cmd[int'(win)*3 +: 3];
    assign win_sz  = port_sz[int'(win)*2 +: 2];

    always_comb begin
        state_nxt = state;
        rr_nxt    = rr_ptr;
        lock_nxt  = lock;
        bcnt_nxt  = bcnt;
        port_ack  = '0;
        port_dack = '0;
        cmd_put   = 1'b0;
        cmd_data  = '0;
        data_put  = 1'b0;
        data_out  = '0;
        busy      = 1'b0;
        if (resetbar) begin
            case (state)
                IDLE: begin
                    if (found) begin
                        port_ack[win] = 1'b1;
                        cmd_put       = 1'b1;
                        cmd_data      = {win_cmd, port_addr[int'(win)*AW +: AW], win_sz,
                                         port_op[int'(win)*3 +: 3], win};
                        if (is_wr[win]) begin
                            data_put = 1'b1;
                            data_out = port_din[int'(win)*DW +: DW];
                        end
                        rr_nxt = (int'(win) == NPORTS - 1) ? '0 : win + PIDW'(1);
                        // Remaining beats after the first: (sz+1)*8-1.
                        if (win_cmd == CMD_BLW) begin
                            state_nxt = BURST;
                            lock_nxt  = win;
                            bcnt_nxt  = {win_sz, 3'b111};
                        end
                    end
                end
                BURST: begin
                    busy            = 1'b1;
                    data_put        = port_wvalid[lock] & ~data_full;
                    data_out        = port_din[int'(lock)*DW +: DW];
                    port_dack[lock] = data_put;
                    if (data_put) begin
                        bcnt_nxt = bcnt - 5'd1;
                        if (bcnt == 5'd1) state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetbar) begin
            state  <= IDLE;
            rr_ptr <= '0;
            lock   <= '0;
            bcnt   <= '0;
        end else begin
            state  <= state_nxt;
            rr_ptr <= rr_nxt;
            lock   <= lock_nxt;
            bcnt   <= bcnt_nxt;
        end
    end

endmodule

// File: tb/tb_ddr3_cmd_arbiter.sv
// Directed bench for ddr3_cmd_arbiter with four ports: reset, round-robin,
// BLW bursts with stalls, work-conserving arbitration and reset mid-burst.
module tb_ddr3_cmd_arbiter;

    localparam int NPORTS = 4;
    localparam int PIDW   = 2;
    localparam int DW     = 16;
    localparam int AW     = 26;
    localparam int CW     = 3 + AW + 2 + 3 + PIDW;

    logic                    clk = 1'b0;
    logic                    resetbar, ready, cmd_full, data_full;
    logic [3*NPORTS-1:0]     port_cmd;
    logic [AW*NPORTS-1:0]    port_addr;
    logic [2*NPORTS-1:0]     port_sz;
    logic [3*NPORTS-1:0]     port_op;
    logic [DW*NPORTS-1:0]    port_din;
    logic [NPORTS-1:0]       port_wvalid;
    logic [NPORTS-1:0]       port_ack, port_dack;
    logic                    cmd_put, data_put, busy;
    logic [CW-1:0]           cmd_data;
    logic [DW-1:0]           data_out;

    int total = 0;
    int bad   = 0;
    int puts;

    ddr3_cmd_arbiter #(.NPORTS(NPORTS), .PIDW(PIDW), .DW(DW), .AW(AW)) dut (
        .clk(clk), .resetbar(resetbar), .ready(ready),
        .port_cmd(port_cmd), .port_addr(port_addr), .port_sz(port_sz),
        .port_op(port_op), .port_din(port_din), .port_wvalid(port_wvalid),
        .port_ack(port_ack), .port_dack(port_dack),
        .cmd_full(cmd_full), .cmd_put(cmd_put), .cmd_data(cmd_data),
        .data_full(data_full), .data_put(data_put), .data_out(data_out),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic set_port(input int p, input logic [2:0] c, input logic [AW-1:0] a,
                            input logic [1:0] s, input logic [2:0] o, input logic [DW-1:0] d);
        port_cmd[p*3 +: 3]   = c;
        port_addr[p*AW +: AW] = a;
        port_sz[p*2 +: 2]    = s;
        port_op[p*3 +: 3]    = o;
        port_din[p*DW +: DW] = d;
    endtask

    function automatic logic [CW-1:0] mk(input logic [2:0] c, input logic [AW-1:0] a,
                                         input logic [1:0] s, input logic [2:0] o,
                                         input logic [PIDW-1:0] pid);
        return {c, a, s, o, pid};
    endfunction

    initial begin
        resetbar = 1'b0; ready = 1'b1; cmd_full = 1'b0; data_full = 1'b0;
        port_wvalid = '0;
        port_cmd = '0; port_addr = '0; port_sz = '0; port_op = '0; port_din = '0;
        for (int p = 0; p < NPORTS; p++)
            set_port(p, 3'd1, AW'(100 + p), 2'd0, 3'd0, DW'(16'hA000 + p));

        // Reset held with every port requesting
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("rst_ack", port_ack, 0);
            chk("rst_cmd_put", cmd_put, 0);
            chk("rst_data_put", data_put, 0);
            chk("rst_busy", busy, 0);
            tick();
        end
        resetbar = 1'b1;
        settle();
        chk("first_ack", port_ack, 4'b0001);
        chk("first_cmd_data", cmd_data, mk(3'd1, 26'd100, 2'd0, 3'd0, 2'd0));
        tick();

        // Round-robin over continuous SCR requests
        for (int i = 1; i <= 5; i++) begin
            settle();
            chk("rr_ack", port_ack, 64'(4'b0001 << (i % 4)));
            chk("rr_pid", cmd_data[PIDW-1:0], 64'(i % 4));
            tick();
        end
        for (int p = 0; p < NPORTS; p++) set_port(p, 3'd0, '0, 2'd0, 3'd0, '0);
        settle();
        chk("idle_cmd_put", cmd_put, 0);
        tick();

        // rr_ptr = 2: cmd 7 ignored, cmd_full and ready gate acceptance
        set_port(2, 3'd7, 26'd150, 2'd0, 3'd0, 16'h0);
        settle();
        chk("cmd7_ack", port_ack, 0);
        tick();
        set_port(2, 3'd1, 26'd150, 2'd0, 3'd0, 16'h0);
        cmd_full = 1'b1;
        settle();
        chk("cmdfull_ack", port_ack, 0);
        tick();
        cmd_full = 1'b0; ready = 1'b0;
        settle();
        chk("notready_ack", port_ack, 0);
        tick();
        ready = 1'b1;
        settle();
        chk("ready_ack", port_ack, 4'b0100);
        tick();
        set_port(2, 3'd0, '0, 2'd0, 3'd0, '0);

        // rr_ptr = 3: BLW sz=1 on port 1, then 15 locked beats
        set_port(1, 3'd4, 26'd200, 2'd1, 3'd0, 16'hB000);
        port_wvalid = 4'b0010;
        settle();
        chk("blw_ack", port_ack, 4'b0010);
        chk("blw_cmd_data", cmd_data, mk(3'd4, 26'd200, 2'd1, 3'd0, 2'd1));
        chk("blw_first_put", data_put, 1);
        chk("blw_first_data", data_out, 16'hB000);
        chk("blw_first_dack", port_dack, 0);
        tick();
        set_port(1, 3'd0, '0, 2'd0, 3'd0, 16'hB000);
        set_port(0, 3'd1, 26'd100, 2'd0, 3'd0, 16'hA000);
        for (int b = 1; b <= 15; b++) begin
            port_din[1*DW +: DW] = DW'(16'hB000 + b);
            settle();
            chk("blw_dack", port_dack, 4'b0010);
            chk("blw_data", data_out, 64'(16'hB000 + b));
            chk("blw_busy", busy, 1);
            chk("blw_no_ack", port_ack, 0);
            tick();
        end
        settle();
        chk("post_blw_ack", port_ack, 4'b0001);
        chk("post_blw_busy", busy, 0);
        chk("post_blw_dack", port_dack, 0);
        tick();
        set_port(0, 3'd0, '0, 2'd0, 3'd0, '0);
        port_wvalid = '0;

        // rr_ptr = 1: BLW sz=0 on port 2 with a 3-cycle data_full stall
        puts = 0;
        set_port(2, 3'd4, 26'd300, 2'd0, 3'd0, 16'hC000);
        port_wvalid = 4'b0100;
        settle();
        chk("stall_ack", port_ack, 4'b0100);
        puts += int'(data_put);
        tick();
        set_port(2, 3'd0, '0, 2'd0, 3'd0, 16'hC000);
        for (int c = 0; c < 10; c++) begin
            data_full = (c >= 3 && c < 6);
            port_din[2*DW +: DW] = DW'(16'hC001 + c);
            settle();
            chk("stall_put", data_put, 64'(!data_full));
            chk("stall_dack", port_dack, data_full ? 64'd0 : 64'd4);
            chk("stall_busy", busy, 1);
            puts += int'(data_put);
            tick();
        end
        data_full = 1'b0;
        settle();
        chk("stall_end_busy", busy, 0);
        chk("stall_total_puts", 64'(puts), 8);
        tick();
        port_wvalid = '0;

        // rr_ptr = 3: blocked SCW on port 0 must not stall BLR on port 1
        data_full = 1'b1;
        set_port(0, 3'd2, 26'd100, 2'd0, 3'd0, 16'hA000);
        set_port(1, 3'd3, 26'd201, 2'd0, 3'd0, 16'h0);
        settle();
        chk("wc_read_ack", port_ack, 4'b0010);
        chk("wc_read_cmd", cmd_data, mk(3'd3, 26'd201, 2'd0, 3'd0, 2'd1));
        chk("wc_read_put", data_put, 0);
        tick();
        set_port(1, 3'd0, '0, 2'd0, 3'd0, '0);
        settle();
        chk("wc_blocked_ack", port_ack, 0);
        tick();
        data_full = 1'b0;
        settle();
        chk("wc_write_ack", port_ack, 4'b0001);
        chk("wc_write_cmd", cmd_data, mk(3'd2, 26'd100, 2'd0, 3'd0, 2'd0));
        chk("wc_write_data", data_out, 16'hA000);
        tick();
        set_port(0, 3'd0, '0, 2'd0, 3'd0, '0);

        // rr_ptr = 1: reset at beat 4 of a 32-beat BLW
        set_port(1, 3'd4, 26'd400, 2'd3, 3'd0, 16'hD000);
        port_wvalid = 4'b0010;
        settle();
        chk("rb_ack", port_ack, 4'b0010);
        tick();
        set_port(1, 3'd0, '0, 2'd0, 3'd0, 16'hD000);
        for (int b = 2; b <= 4; b++) begin
            settle();
            chk("rb_dack", port_dack, 4'b0010);
            tick();
        end
        resetbar = 1'b0;
        settle();
        chk("rb_rst_busy", busy, 0);
        chk("rb_rst_put", data_put, 0);
        tick();
        resetbar = 1'b1;
        set_port(3, 3'd1, 26'd500, 2'd0, 3'd0, 16'h0);
        settle();
        chk("rb_after_busy", busy, 0);
        chk("rb_after_dack", port_dack, 0);
        chk("rb_after_ack", port_ack, 4'b1000);
        chk("rb_after_cmd", cmd_data, mk(3'd1, 26'd500, 2'd0, 3'd0, 2'd3));
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
